// File: rtl/spi_pkg.sv
// Shared SPI frame geometry and peripheral FSM encoding, used by spi_peripheral and spi_controller.
package spi_pkg;

   localparam int SPI_N_WORDS = 4;
   localparam int SPI_WORD_W  = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } spi_per_state_t;

endpackage

// File: rtl/spi_edge_det.sv
// One-flop edge detector on clk; the input is already in the clk domain, so no synchronizer.
module spi_edge_det (
   input  logic clk,
   input  logic n_rst,
   input  logic sig,
   output logic rise,
   output logic fall
);

   logic sig_q;

   always_ff @(posedge clk) begin
      if (!n_rst) sig_q <= 1'b0;
      else        sig_q <= sig;
   end

   assign rise = sig & ~sig_q;
   assign fall = ~sig & sig_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target: exchanges one N_WORDS x WORD_W frame, MSB first, per SS-low window.
module spi_peripheral
   import spi_pkg::*;
#(
   parameter int WORD_W = SPI_WORD_W
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              SCK,
   input  logic              SS,
   input  logic              MOSI,
   output logic              MISO,
   input  logic [WORD_W-1:0] word_0_in,
   input  logic [WORD_W-1:0] word_1_in,
   input  logic [WORD_W-1:0] word_2_in,
   input  logic [WORD_W-1:0] word_3_in,
   output logic [WORD_W-1:0] word_0_out,
   output logic [WORD_W-1:0] word_1_out,
   output logic [WORD_W-1:0] word_2_out,
   output logic [WORD_W-1:0] word_3_out,
   output logic              frame_done,
   output logic              frame_abort,
   output logic              busy,
   output logic [1:0]        fsm_state
);

   localparam int N_WORDS = SPI_N_WORDS;
   localparam int FRAME_W = N_WORDS * WORD_W;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

   spi_per_state_t     state;
   logic [CNT_W-1:0]   bit_cnt;
   logic [FRAME_W-1:0] tx_sr;
   logic [FRAME_W-1:0] rx_sr;
   logic               done_first;
   logic               sck_rise;
   logic               sck_fall;

   spi_edge_det u_sck_edge (
      .clk   (clk),
      .n_rst (n_rst),
      .sig   (SCK),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         tx_sr       <= '0;
         rx_sr       <= '0;
         done_first  <= 1'b0;
         word_0_out  <= '0;
         word_1_out  <= '0;
         word_2_out  <= '0;
         word_3_out  <= '0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         case (state)
            IDLE: begin
               if (!SS) begin
                  tx_sr   <= {word_0_in, word_1_in, word_2_in, word_3_in};
                  bit_cnt <= '0;
                  state   <= ACTIVE;
               end
            end
            ACTIVE: begin
               // SS release takes priority over a coincident SCK rise: that bit is dropped.
               if (SS) begin
                  frame_abort <= 1'b1;
                  state       <= IDLE;
               end else if (sck_rise) begin
                  rx_sr   <= {rx_sr[FRAME_W-2:0], MOSI};
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == LAST_BIT) begin
                     done_first <= 1'b1;
                     state      <= DONE;
                  end
               end else if (sck_fall && bit_cnt != '0) begin
                  // The first bit is presented at SS fall, so only post-capture falls advance.
                  tx_sr <= tx_sr << 1;
               end
            end
            DONE: begin
               if (done_first) begin
                  word_0_out <= rx_sr[FRAME_W-1 -: WORD_W];
                  word_1_out <= rx_sr[FRAME_W-1-WORD_W -: WORD_W];
                  word_2_out <= rx_sr[FRAME_W-1-2*WORD_W -: WORD_W];
                  word_3_out <= rx_sr[FRAME_W-1-3*WORD_W -: WORD_W];
                  frame_done <= 1'b1;
                  done_first <= 1'b0;
               end
               if (SS) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign MISO      = (state == ACTIVE && !SS) ? tx_sr[FRAME_W-1] : 1'b0;
   assign busy      = (state == ACTIVE);
   assign fsm_state = state;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: plays the SPI controller and checks against a frame-level model.
module tb_spi_peripheral;
   import spi_pkg::*;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       SCK;
   logic       SS;
   logic       MOSI;
   logic       MISO;
   logic [7:0] word_in [4];
   logic [7:0] w0_out, w1_out, w2_out, w3_out;
   logic       frame_done;
   logic       frame_abort;
   logic       busy;
   logic [1:0] fsm_state;

   int         n_checks = 0;
   int         n_fail = 0;
   int         done_cnt = 0;
   int         abort_cnt = 0;
   logic [31:0] exp_words;
   logic [0:0]  exp_q[$];

   spi_peripheral dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .SCK         (SCK),
      .SS          (SS),
      .MOSI        (MOSI),
      .MISO        (MISO),
      .word_0_in   (word_in[0]),
      .word_1_in   (word_in[1]),
      .word_2_in   (word_in[2]),
      .word_3_in   (word_in[3]),
      .word_0_out  (w0_out),
      .word_1_out  (w1_out),
      .word_2_out  (w2_out),
      .word_3_out  (w3_out),
      .frame_done  (frame_done),
      .frame_abort (frame_abort),
      .busy        (busy),
      .fsm_state   (fsm_state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done === 1'b1)  done_cnt++;
      if (frame_abort === 1'b1) abort_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] dut_words();
      return {w0_out, w1_out, w2_out, w3_out};
   endfunction

   task automatic set_words(input logic [31:0] w);
      word_in[0] = w[31:24];
      word_in[1] = w[23:16];
      word_in[2] = w[15:8];
      word_in[3] = w[7:0];
   endtask

   // Controller side of one frame: stop_bit < 32 aborts, reset_bit >= 0 resets before that bit.
   task automatic run_frame(input logic [31:0] mosi_data, input int stop_bit,
                            input int reset_bit, input bit zero_mid);
      logic [31:0] tx_load;
      logic [31:0] rx_miso;
      logic [0:0]  exp_bit;
      int          d0;
      int          a0;
      tx_load = {word_in[0], word_in[1], word_in[2], word_in[3]};
      rx_miso = '0;
      d0 = done_cnt;
      a0 = abort_cnt;
      for (int i = 0; i < 32; i++) exp_q.push_back(tx_load[31-i]);
      SS = 1'b0;
      tick();
      tick();
      check_eq("busy_start", busy, 1'b1);
      for (int i = 0; i < stop_bit; i++) begin
         if (i == reset_bit) begin
            n_rst = 1'b0;
            SS    = 1'b1;
            tick();
            exp_words = '0;
            exp_q.delete();
            check_eq("rst_state", fsm_state, IDLE);
            check_eq("rst_busy", busy, 1'b0);
            check_eq("rst_miso", MISO, 1'b0);
            check_eq("rst_words", dut_words(), exp_words);
            n_rst = 1'b1;
            tick();
            check_eq("rst_no_done", done_cnt - d0, 0);
            check_eq("rst_no_abort", abort_cnt - a0, 0);
            return;
         end
         if (zero_mid && i == 8) set_words(32'h0);
         MOSI = mosi_data[31-i];
         tick();
         tick();
         exp_bit = exp_q.pop_front();
         check_eq($sformatf("miso_b%0d", i), MISO, exp_bit);
         rx_miso[31-i] = MISO;
         SCK = 1'b1;
         tick();
         if (i == 31) begin
            tick();
            exp_words = mosi_data;
            check_eq("done_latency", frame_done, 1'b1);
            check_eq("words_out", dut_words(), exp_words);
            check_eq("busy_done", busy, 1'b0);
         end else begin
            tick();
         end
         SCK = 1'b0;
      end
      tick();
      SS = 1'b1;
      tick();
      if (stop_bit >= 32) begin
         check_eq("done_count", done_cnt - d0, 1);
         check_eq("no_abort", abort_cnt - a0, 0);
         check_eq("miso_stream", rx_miso, tx_load);
         check_eq("idle_miso", MISO, 1'b0);
      end else begin
         check_eq("abort_pulse", frame_abort, 1'b1);
         check_eq("abort_busy", busy, 1'b0);
         check_eq("abort_words", dut_words(), exp_words);
         tick();
         check_eq("abort_count", abort_cnt - a0, 1);
         check_eq("abort_no_done", done_cnt - d0, 0);
         check_eq("abort_idle", fsm_state, IDLE);
         exp_q.delete();
      end
   endtask

   initial begin
      int stop;
      n_rst = 1'b0;
      SCK   = 1'b0;
      SS    = 1'b1;
      MOSI  = 1'b0;
      set_words(32'h0);
      exp_words = '0;
      tick();
      tick();
      check_eq("reset_state", fsm_state, IDLE);
      check_eq("reset_words", dut_words(), 32'h0);
      check_eq("reset_miso", MISO, 1'b0);
      check_eq("reset_pulses", {frame_done, frame_abort, busy}, 3'b000);
      n_rst = 1'b1;
      tick();

      // Loopback pattern: controller sends FA FB FC FE, peripheral returns FE FC FB FA.
      set_words(32'hFEFCFBFA);
      run_frame(32'hFAFBFCFE, 32, -1, 1'b0);
      tick();

      set_words($urandom);
      run_frame($urandom, 13, -1, 1'b0);
      tick();

      set_words($urandom | 32'h80808080);
      run_frame($urandom, 32, -1, 1'b1);
      tick();

      // Back-to-back frames separated by a single SS-high clock.
      set_words($urandom);
      run_frame($urandom, 32, -1, 1'b0);
      set_words($urandom);
      run_frame(32'hA5A5A5A5, 32, -1, 1'b0);
      check_eq("a5_words", dut_words(), 32'hA5A5A5A5);
      tick();

      set_words($urandom);
      run_frame($urandom, 32, 20, 1'b0);
      set_words($urandom);
      run_frame($urandom, 32, -1, 1'b0);
      tick();

      for (int k = 0; k < 6; k++) begin
         stop = ($urandom_range(0, 1) == 0) ? 32 : int'($urandom_range(1, 31));
         set_words($urandom);
         run_frame($urandom, stop, -1, 1'b0);
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
